fifo_rd_serializer: RTL and testbench

Read-side consumer for the dual-clock FIFO wrapper. It sits in the `clk_out` domain and drives the wrapper's `b_rdy` ready input. It accepts words from the wrapper's `data_out`/`data_out_vld` pair, which arrive one cycle after ready is asserted, and buffers them in a 2-entry skid buffer. It then transmits each word as an asynchronous serial frame on `tx_bit`.

---
 rtl/fifo_rd_serializer.sv | 231 +++++++++++++++++++++++
 tb/tb_fifo_rd_serializer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// fifo_rd_serializer
//
// Read-side consumer for the dual-clock FIFO wrapper (clk_out domain). Pulls
// words from the wrapper with a ready/valid pair whose valid answers one cycle
// after ready, parks them in a 2-entry skid buffer, and sends each word as an
// asynchronous serial frame: start bit (0), DATA_W data bits LSB first,
// optional even-parity bit, stop bit (1). Every bit is held BIT_CYC cycles.
//
// Handshake: b_rdy high in cycle N grants the wrapper permission to present
// exactly one word with data_in_vld in cycle N+1. A word is accepted on the
// rising edge where data_in_vld is high and the buffer has room. Nothing else
// qualifies the transfer, and there is no back-pressure on the valid side.
//
// Parameters
//   DATA_W   word width (must match the FIFO wrapper)
//   BIT_CYC  clock cycles per serial bit (>= 2)
//
// Ports
//   clk          read-side clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      word from the wrapper's data_out
//   data_in_vld  word valid from the wrapper's data_out_vld
//   b_rdy        ready to the wrapper (decoded from flops only)
//   tx_bit       serial line, idles high
//   tx_busy      high while a frame is on the line
//   ovf_err      sticky overflow flag, cleared only by reset
//
// Build option
//   FIFO_SER_PARITY_EN  when defined, a PAR bit-time carrying the XOR of all
//                       data bits sits between the last data bit and STOP.
// -----------------------------------------------------------------------------
module fifo_rd_serializer #(
    parameter int DATA_W  = 10,
    parameter int BIT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_vld,
    output logic              b_rdy,
    output logic              tx_bit,
    output logic              tx_busy,
    output logic              ovf_err
);

    localparam int CYC_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef FIFO_SER_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    // ---------------------------------------------------------------- buffer
    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        cnt;
    logic              pend;
    logic              pop;
    logic              push;
    logic              ovf;
    logic [DATA_W-1:0] head;

    // pend remembers last cycle's grant: a word may land this cycle. With one
    // word buffered and one possibly in flight, the buffer is already spoken
    // for. A pop in the current cycle deliberately earns no credit, which
    // keeps b_rdy a pure flop decode.
    assign b_rdy = (cnt == 2'd0) | ((cnt == 2'd1) & ~pend);

    assign head = mem[rd_ptr];
    assign push = data_in_vld & ((cnt != 2'd2) | pop);
    assign ovf  = data_in_vld & (cnt == 2'd2) & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            cnt     <= 2'd0;
            pend    <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            pend <= b_rdy;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (ovf) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ serializer
    state_t            state, state_nx;
    logic [CYC_W-1:0]  cyc, cyc_nx;
    logic [BCNT_W-1:0] bitcnt, bitcnt_nx;
    logic [DATA_W-1:0] sh, sh_nx;
    logic              tx_nx;
    logic              last_cyc;
`ifdef FIFO_SER_PARITY_EN
    logic              par, par_nx;
`endif

    assign last_cyc = (cyc == CYC_W'(BIT_CYC - 1));
    assign tx_busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cyc    <= '0;
            bitcnt <= '0;
            sh     <= '0;
            tx_bit <= 1'b1;
`ifdef FIFO_SER_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            cyc    <= cyc_nx;
            bitcnt <= bitcnt_nx;
            sh     <= sh_nx;
            tx_bit <= tx_nx;
`ifdef FIFO_SER_PARITY_EN
            par    <= par_nx;
`endif
        end
    end

    // tx_bit is registered: each branch loads the value of the bit that starts
    // on this edge, so the line never glitches between bit times.
    always_comb begin
        state_nx  = state;
        cyc_nx    = last_cyc ? '0 : cyc + CYC_W'(1);
        bitcnt_nx = bitcnt;
        sh_nx     = sh;
        tx_nx     = tx_bit;
        pop       = 1'b0;
`ifdef FIFO_SER_PARITY_EN
        par_nx    = par;
`endif
        case (state)
            S_IDLE: begin
                cyc_nx = '0;
                tx_nx  = 1'b1;
                if (cnt != 2'd0) begin
                    pop      = 1'b1;
                    sh_nx    = head;
                    tx_nx    = 1'b0;
                    state_nx = S_START;
`ifdef FIFO_SER_PARITY_EN
                    par_nx   = ^head;
`endif
                end
            end
            S_START: begin
                if (last_cyc) begin
                    bitcnt_nx = '0;
                    tx_nx     = sh[0];
                    state_nx  = S_DATA;
                end
            end
            S_DATA: begin
                if (last_cyc) begin
                    if (bitcnt == BCNT_W'(DATA_W - 1)) begin
`ifdef FIFO_SER_PARITY_EN
                        tx_nx    = par;
                        state_nx = S_PAR;
`else
                        tx_nx    = 1'b1;
                        state_nx = S_STOP;
`endif
                    end else begin
                        sh_nx     = sh >> 1;
                        tx_nx     = sh_nx[0];
                        bitcnt_nx = bitcnt + BCNT_W'(1);
                    end
                end
            end
`ifdef FIFO_SER_PARITY_EN
            S_PAR: begin
                if (last_cyc) begin
                    tx_nx    = 1'b1;
                    state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (last_cyc) begin
                    // Chain straight into the next start bit when a word waits.
                    if (cnt != 2'd0) begin
                        pop      = 1'b1;
                        sh_nx    = head;
                        tx_nx    = 1'b0;
                        state_nx = S_START;
`ifdef FIFO_SER_PARITY_EN
                        par_nx   = ^head;
`endif
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_serializer
//
// Directed self-checking bench for fifo_rd_serializer at DATA_W=10, BIT_CYC=4.
// Inputs are driven and outputs sampled on the falling clock edge. Frame
// layouts are built by the bench from the word (start 0, data LSB first,
// optional even parity, stop 1). The single-frame test also uses a
// hand-written bit list. Define FIFO_SER_PARITY_EN for both DUT and bench to
// exercise the parity build.
// -----------------------------------------------------------------------------
module tb_fifo_rd_serializer;

    localparam int DW = 10;
    localparam int BC = 4;
`ifdef FIFO_SER_PARITY_EN
    localparam int FB = DW + 3;
`else
    localparam int FB = DW + 2;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          data_in_vld;
    logic          b_rdy;
    logic          tx_bit;
    logic          tx_busy;
    logic          ovf_err;

    int n_cmp;
    int n_err;
    logic [DW-1:0] exp_q[$];

    fifo_rd_serializer #(.DATA_W(DW), .BIT_CYC(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_in_vld (data_in_vld),
        .b_rdy       (b_rdy),
        .tx_bit      (tx_bit),
        .tx_busy     (tx_busy),
        .ovf_err     (ovf_err)
    );

    // ------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        data_in_vld = 1'b0;
        data_in     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // --------------------------------------------------------- bench model
    function automatic logic [FB-1:0] frame_of(input logic [DW-1:0] w);
        logic [FB-1:0] v;
        v    = '0;
        v[0] = 1'b0;
        for (int i = 0; i < DW; i++) v[1+i] = w[i];
`ifdef FIFO_SER_PARITY_EN
        v[DW+1] = ^w;
`endif
        v[FB-1] = 1'b1;
        return v;
    endfunction

    // Waits (bounded) for a start bit, then samples each bit mid-way.
    task automatic recv_frame(input int limit, output logic [DW-1:0] w,
                              output logic par_bit, output logic ok,
                              output logic found);
        found   = 1'b0;
        ok      = 1'b1;
        w       = '0;
        par_bit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_bit === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        repeat (BC/2) @(negedge clk);
        if (tx_bit !== 1'b0) ok = 1'b0;
        for (int i = 0; i < DW; i++) begin
            repeat (BC) @(negedge clk);
            w[i] = tx_bit;
        end
`ifdef FIFO_SER_PARITY_EN
        repeat (BC) @(negedge clk);
        par_bit = tx_bit;
`endif
        repeat (BC) @(negedge clk);
        if (tx_bit !== 1'b1) ok = 1'b0;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        data_in_vld = 1'b0;
        #1;
        n_cmp++; if (tx_bit !== 1'b1)  begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx_bit); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf_err); end
        n_cmp++; if (b_rdy !== 1'b1)   begin n_err++; $display("FAIL reset_rdy: got %b expected 1", b_rdy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_bit !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: tx=%b busy=%b expected tx=1 busy=0", tx_bit, tx_busy);
        end
    endtask

    task automatic test_single_frame();
        logic [FB-1:0] exp_bits;
`ifdef FIFO_SER_PARITY_EN
        exp_bits = 13'b1110101001010;   // 0,1,0,1,0,0,1,0,1,0,1,P=1,1
`else
        exp_bits = 12'b110101001010;    // 0,1,0,1,0,0,1,0,1,0,1,1
`endif
        do_reset();
        @(negedge clk);
        data_in     = 10'h2A5;
        data_in_vld = 1'b1;
        @(negedge clk);              // word captured on the edge just passed
        data_in_vld = 1'b0;
        n_cmp++; if (tx_busy !== 1'b0 || tx_bit !== 1'b1) begin
            n_err++; $display("FAIL single_prestart: tx=%b busy=%b expected tx=1 busy=0", tx_bit, tx_busy);
        end
        for (int k = 0; k < FB*BC; k++) begin
            @(negedge clk);
            n_cmp++; if (tx_bit !== exp_bits[k/BC]) begin
                n_err++; $display("FAIL single_bit cyc %0d: got %b expected %b", k, tx_bit, exp_bits[k/BC]);
            end
            n_cmp++; if (tx_busy !== 1'b1) begin
                n_err++; $display("FAIL single_busy cyc %0d: got %b expected 1", k, tx_busy);
            end
        end
        @(negedge clk);
        n_cmp++; if (tx_busy !== 1'b0 || tx_bit !== 1'b1) begin
            n_err++; $display("FAIL single_end: tx=%b busy=%b expected tx=1 busy=0", tx_bit, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*FB-1:0] exp2;
        exp2 = {frame_of(10'h3FF), frame_of(10'h001)};
        do_reset();
        @(negedge clk);
        n_cmp++; if (b_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_first: got %b expected 1", b_rdy); end
        data_in     = 10'h001;
        data_in_vld = 1'b1;
        @(negedge clk);
        // cnt=1 and pend=1: the buffer is fully committed.
        n_cmp++; if (b_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_low: got %b expected 0", b_rdy); end
        data_in     = 10'h3FF;
        @(negedge clk);              // frame 1 start bit is on the line now
        data_in_vld = 1'b0;
        for (int k = 0; k < 2*FB*BC; k++) begin
            n_cmp++; if (tx_bit !== exp2[k/BC] || tx_busy !== 1'b1) begin
                n_err++; $display("FAIL b2b_line cyc %0d: tx=%b busy=%b expected tx=%b busy=1", k, tx_bit, tx_busy, exp2[k/BC]);
            end
            @(negedge clk);
        end
        n_cmp++; if (tx_busy !== 1'b0 || tx_bit !== 1'b1) begin
            n_err++; $display("FAIL b2b_end: tx=%b busy=%b expected tx=1 busy=0", tx_bit, tx_busy);
        end
    endtask

    task automatic test_protocol_source();
        logic [DW-1:0] words [20];
        for (int i = 0; i < 20; i++) begin
            words[i] = DW'((i * 37 + 5) & 10'h3FF);
            exp_q.push_back(words[i]);
        end
        do_reset();
        fork
            begin : source
                logic granted;
                int   idx;
                granted = 1'b0;
                idx     = 0;
                for (int g = 0; g < 5000 && idx < 20; g++) begin
                    @(negedge clk);
                    if (granted) begin
                        data_in     = words[idx];
                        data_in_vld = 1'b1;
                        idx++;
                    end else begin
                        data_in_vld = 1'b0;
                    end
                    granted = b_rdy;
                end
                @(negedge clk);
                data_in_vld = 1'b0;
            end
            begin : sink
                logic [DW-1:0] w;
                logic p, ok, found;
                for (int f = 0; f < 20; f++) begin
                    recv_frame(300, w, p, ok, found);
                    n_cmp++;
                    if (!found) begin
                        n_err++; $display("FAIL proto_timeout frame %0d: no start bit seen", f);
                        break;
                    end
                    if (w !== exp_q[0] || !ok) begin
                        n_err++; $display("FAIL proto_word frame %0d: got %h framing_ok=%b expected %h", f, w, ok, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        join
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL proto_ovf: got %b expected 0", ovf_err); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] words [4];
        int lows;
        words[0] = 10'h011; words[1] = 10'h022; words[2] = 10'h033; words[3] = 10'h044;
        // Word 1 leaves for the line on the edge after capture, words 2 and 3
        // fill the buffer, word 4 meets cnt=2 with no pop and is dropped.
        exp_q.push_back(words[0]);
        exp_q.push_back(words[1]);
        exp_q.push_back(words[2]);
        do_reset();
        fork
            begin : drive
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    data_in     = words[i];
                    data_in_vld = 1'b1;
                    if (i == 3) begin
                        n_cmp++; if (ovf_err !== 1'b0) begin
                            n_err++; $display("FAIL ovf_early: got %b expected 0", ovf_err);
                        end
                    end
                end
                @(negedge clk);
                data_in_vld = 1'b0;
                n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", ovf_err); end
            end
            begin : sink
                logic [DW-1:0] w;
                logic p, ok, found;
                for (int f = 0; f < 3; f++) begin
                    recv_frame(300, w, p, ok, found);
                    n_cmp++;
                    if (!found) begin
                        n_err++; $display("FAIL ovf_timeout frame %0d: no start bit seen", f);
                        break;
                    end
                    if (w !== exp_q[0] || !ok) begin
                        n_err++; $display("FAIL ovf_word frame %0d: got %h framing_ok=%b expected %h", f, w, ok, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        join
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_bit !== 1'b1) lows++;
        end
        n_cmp++; if (lows != 0) begin n_err++; $display("FAIL ovf_dropped_sent: low cycles %0d expected 0", lows); end
        n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int activity;
        do_reset();
        @(negedge clk);
        data_in     = 10'h001;
        data_in_vld = 1'b1;
        @(negedge clk);
        data_in     = 10'h2A5;       // second word sits in the buffer
        @(negedge clk);              // frame start bit, cycle 0
        data_in_vld = 1'b0;
        repeat (4*BC) @(negedge clk); // inside data bit 3 (a 0 for 10'h001)
        n_cmp++; if (tx_bit !== 1'b0 || tx_busy !== 1'b1) begin
            n_err++; $display("FAIL mid_before: tx=%b busy=%b expected tx=0 busy=1", tx_bit, tx_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_bit !== 1'b1)  begin n_err++; $display("FAIL mid_tx: got %b expected 1", tx_bit); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (b_rdy !== 1'b1)   begin n_err++; $display("FAIL mid_rdy: got %b expected 1", b_rdy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_bit !== 1'b1 || tx_busy !== 1'b0) activity++;
        end
        n_cmp++; if (activity != 0) begin n_err++; $display("FAIL mid_stale: active cycles %0d expected 0", activity); end
    endtask

`ifdef FIFO_SER_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] w;
        logic p, ok, found;
        int busy_cyc;
        do_reset();
        fork
            begin
                @(negedge clk);
                data_in     = 10'h2A5;
                data_in_vld = 1'b1;
                @(negedge clk);
                data_in_vld = 1'b0;
            end
            recv_frame(50, w, p, ok, found);
            begin
                busy_cyc = 0;
                repeat (80) begin
                    @(negedge clk);
                    if (tx_busy === 1'b1) busy_cyc++;
                end
            end
        join
        n_cmp++; if (!found || w !== 10'h2A5 || !ok) begin
            n_err++; $display("FAIL par_word_2a5: got %h found=%b ok=%b expected 2a5", w, found, ok);
        end
        n_cmp++; if (p !== 1'b1) begin n_err++; $display("FAIL par_bit_2a5: got %b expected 1", p); end
        n_cmp++; if (busy_cyc != 52) begin n_err++; $display("FAIL par_busy_len: got %0d expected 52", busy_cyc); end
        fork
            begin
                @(negedge clk);
                data_in     = 10'h003;
                data_in_vld = 1'b1;
                @(negedge clk);
                data_in_vld = 1'b0;
            end
            recv_frame(50, w, p, ok, found);
        join
        n_cmp++; if (!found || w !== 10'h003 || !ok) begin
            n_err++; $display("FAIL par_word_003: got %h found=%b ok=%b expected 003", w, found, ok);
        end
        n_cmp++; if (p !== 1'b0) begin n_err++; $display("FAIL par_bit_003: got %b expected 0", p); end
    endtask
`endif

    // ---------------------------------------------------------------- main
    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        data_in     = '0;
        data_in_vld = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_protocol_source();
        test_overflow();
        test_reset();               // ovf_err must clear on reset
        test_reset_midframe();
`ifdef FIFO_SER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
